// File: rtl/jtframe_dip_pkg.sv
// Shared definitions for the jtframe OSD status decoder: status bit map,
// pause FSM encoding and the framework-control decode helper.
package jtframe_dip_pkg;

  localparam int PAUSE_BIT = 1;
  localparam int WIDE_BIT  = 2;
  localparam int SCAN_LSB  = 3;   // scanlines occupy bits 5:3
  localparam int TEST_BIT  = 6;
  localparam int PSG_BIT   = 7;
  localparam int FM_BIT    = 8;
  localparam int MIX_BIT   = 9;
  localparam int FX_LSB    = 10;  // FX level occupies bits 11:10
  localparam int FLIP_BIT  = 12;
  localparam int ROT_BIT   = 13;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PEND_ON  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_PEND_OFF = 2'd3
  } pause_state_t;

  typedef struct packed {
    logic [7:0] arx;
    logic [7:0] ary;
    logic [1:0] rotate;
    logic       rot_control;
    logic [2:0] scanlines;
    logic       en_mixing;
    logic       enable_fm;
    logic       enable_psg;
    logic       dip_test;
    logic       dip_flip;
    logic [1:0] fxlevel;
  } fw_ctrl_t;

  // Translate the framework part of a status word into control values.
  function automatic fw_ctrl_t decode_fw(input logic [13:2] s, input logic vertical,
                                         input logic mister);
    fw_ctrl_t f;
    logic     tate;
    logic     rot_control;
    logic     swap_ar;
    tate          = vertical & (mister ? s[ROT_BIT] : 1'b1);
    rot_control   = ~mister & s[ROT_BIT];
    swap_ar       = vertical ? tate : 1'b1;
    f.arx         = s[WIDE_BIT] ? 8'd16 : (swap_ar ? 8'd4 : 8'd3);
    f.ary         = s[WIDE_BIT] ? 8'd9  : (swap_ar ? 8'd3 : 8'd4);
    f.rotate      = {s[FLIP_BIT], tate & ~rot_control};
    f.rot_control = rot_control;
    f.scanlines   = s[SCAN_LSB +: 3];
    f.en_mixing   = ~s[MIX_BIT];
    f.enable_fm   = ~s[FM_BIT];
    f.enable_psg  = ~s[PSG_BIT];
    f.dip_test    = ~s[TEST_BIT];
    f.dip_flip    = s[FLIP_BIT];
    f.fxlevel     = 2'b10 ^ s[FX_LSB +: 2];
    return f;
  endfunction

endpackage

// File: rtl/jtframe_dip_filter.sv
// Settle filter for the raw status word: a value is committed only after it
// has been seen unchanged for SETTLE consecutive cycles.
module jtframe_dip_filter #(
  parameter int             W      = 64,
  parameter int             SETTLE = 1024,
  parameter logic [W-1:0]   INIT   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] status,
  output logic         load,       // commit happens at the coming clock edge
  output logic [W-1:0] next_word,  // value being committed when load is high
  output logic         change      // one-cycle strobe after a commit
);

  localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [W-1:0]  candidate;
  logic [W-1:0]  committed;
  logic [CW-1:0] cnt;

  assign load      = (cnt == LAST) && (candidate != committed);
  assign next_word = candidate;

  // Track stability of the sampled status and commit once it has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= INIT;
      committed <= INIT;
      cnt       <= '0;
      change    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so cnt and candidate are compared consistently.
      candidate <= status;
      if (status != candidate) cnt <= '0;
      else if (cnt != LAST)    cnt <= cnt + 1'b1;
      change <= load;
      if (load) committed <= candidate;
    end
  end

endmodule

// File: rtl/jtframe_dip_ctrl.sv
// OSD status decoder: settle filter, framework/core DIP decode and a
// vblank-aligned pause handshake with timeout.
module jtframe_dip_ctrl
  import jtframe_dip_pkg::*;
#(
  parameter int              SW       = 64,
  parameter int              DIPLSB   = 16,
  parameter int              DIPW     = 16,
  parameter logic [DIPW-1:0] DIP_DEF  = '0,
  parameter int              SETTLE   = 1024,
  parameter int              PAUSE_TO = 1048576,
  parameter int              VERTICAL = 0,
  parameter int              MISTER   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW-1:0]   status,
  input  logic            game_pause,
  input  logic            vb,
  output logic [7:0]      hdmi_arx,
  output logic [7:0]      hdmi_ary,
  output logic [1:0]      rotate,
  output logic            rot_control,
  output logic [2:0]      scanlines,
  output logic            en_mixing,
  output logic            enable_fm,
  output logic            enable_psg,
  output logic            dip_test,
  output logic            dip_flip,
  output logic [1:0]      dip_fxlevel,
  output logic [DIPW-1:0] dip_core,
  output logic            dip_pause,
  output logic            dip_change
);

  localparam logic [SW-1:0] INIT   = SW'(DIP_DEF) << DIPLSB;
  localparam fw_ctrl_t      FW_RST = decode_fw(INIT[13:2], VERTICAL != 0, MISTER != 0);
  localparam int            TW     = (PAUSE_TO > 1) ? $clog2(PAUSE_TO) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(PAUSE_TO - 1);

  logic            load;
  logic [SW-1:0]   next_word;
  fw_ctrl_t        fw;
  logic            pause_req;
  logic            vb_l;
  logic            vb_edge;
  logic            want;
  logic            timeout;
  pause_state_t    state;
  logic [TW-1:0]   tcnt;
  logic            pause_n;
  logic            unused_status;

  jtframe_dip_filter #(.W(SW), .SETTLE(SETTLE), .INIT(INIT)) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .status    (status),
    .load      (load),
    .next_word (next_word),
    .change    (dip_change)
  );

  // Bits with no decoded meaning are intentionally dropped.
  assign unused_status = ^next_word;

  // Decode registers load together with the commit, so they update in the
  // same cycle the change strobe is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw        <= FW_RST;
      dip_core  <= DIP_DEF;
      pause_req <= INIT[PAUSE_BIT];
    end else if (load) begin
      fw        <= decode_fw(next_word[13:2], VERTICAL != 0, MISTER != 0);
      dip_core  <= next_word[DIPLSB +: DIPW];
      pause_req <= next_word[PAUSE_BIT];
    end
  end

  assign hdmi_arx    = fw.arx;
  assign hdmi_ary    = fw.ary;
  assign rotate      = fw.rotate;
  assign rot_control = fw.rot_control;
  assign scanlines   = fw.scanlines;
  assign en_mixing   = fw.en_mixing;
  assign enable_fm   = fw.enable_fm;
  assign enable_psg  = fw.enable_psg;
  assign dip_flip    = fw.dip_flip;
  assign dip_fxlevel = fw.fxlevel;

`ifdef SIMULATION
  assign dip_pause = 1'b1;
`ifdef DIP_TEST
  assign dip_test  = fw.dip_test;
`else
  assign dip_test  = 1'b1;
`endif
`else
  assign dip_pause = pause_n;
  assign dip_test  = fw.dip_test;
`endif

  // vblank rising-edge detector; held high out of reset so a vb that is
  // already high on release does not count as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vb_l <= 1'b1;
    else        vb_l <= vb;
  end

  assign vb_edge = vb & ~vb_l;
  assign want    = pause_req | game_pause;
  assign timeout = (tcnt == TO_LAST);

  // Pause handshake: transitions wait for a vblank edge or the timeout;
  // a withdrawn request always wins over a simultaneous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      tcnt    <= '0;
      pause_n <= 1'b1;
    end else begin
      // NOTE: tcnt defaults to zero and only the waiting branches advance
      // it, so every state entry starts the timeout from scratch.
      tcnt <= '0;
      case (state)
        ST_RUN:
          if (want) state <= ST_PEND_ON;
        ST_PEND_ON:
          if (!want) state <= ST_RUN;
          else if (vb_edge || timeout) begin
            state   <= ST_PAUSED;
            pause_n <= 1'b0;
          end else tcnt <= tcnt + 1'b1;
        ST_PAUSED:
          if (!want) state <= ST_PEND_OFF;
        ST_PEND_OFF:
          if (want) state <= ST_PAUSED;
          else if (vb_edge || timeout) begin
            state   <= ST_RUN;
            pause_n <= 1'b1;
          end else tcnt <= tcnt + 1'b1;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_dip_ctrl.sv
// Scoreboard bench for jtframe_dip_ctrl: two instances (horizontal MiSTer and
// vertical MiSTer) share the status bus; expected decodes and pause edges are
// queued by the stimulus and consumed by independent monitors.
module tb_jtframe_dip_ctrl;

  localparam int          SETTLE  = 16;
  localparam logic [15:0] DIP_DEF = 16'hA5C3;
  localparam logic [63:0] INIT    = {32'd0, DIP_DEF, 16'd0};

  typedef struct packed {
    logic [7:0]  arx;
    logic [7:0]  ary;
    logic [1:0]  rotate;
    logic        rotc;
    logic [2:0]  scan;
    logic        mix;
    logic        fm;
    logic        psg;
    logic        test;
    logic        flip;
    logic [1:0]  fx;
    logic [15:0] core;
  } dec_t;

  typedef struct packed {
    logic        val;
    logic [31:0] cyc;
  } pev_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] status;
  logic        gp_a, vb_a, gp_v, vb_v;

  logic [7:0]  arx_a, ary_a, arx_v, ary_v;
  logic [1:0]  rot_a, rot_v, fx_a, fx_v;
  logic        rotc_a, rotc_v, mix_a, mix_v, fm_a, fm_v, psg_a, psg_v;
  logic        test_a, test_v, flip_a, flip_v, pause_a, pause_v, chg_a, chg_v;
  logic [2:0]  scan_a, scan_v;
  logic [15:0] core_a, core_v;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] cyc      = 0;
  dec_t        exp_a[$];
  dec_t        exp_v[$];
  pev_t        pex_a[$];
  pev_t        pex_v[$];
  logic        prev_pause_a = 1'b1;
  logic        prev_pause_v = 1'b1;

  logic [63:0] cur_word;
  logic [63:0] committed;
  int          run;

  jtframe_dip_ctrl #(
    .SW(64), .DIPLSB(16), .DIPW(16), .DIP_DEF(DIP_DEF), .SETTLE(SETTLE),
    .PAUSE_TO(1024), .VERTICAL(0), .MISTER(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .status(status), .game_pause(gp_a), .vb(vb_a),
    .hdmi_arx(arx_a), .hdmi_ary(ary_a), .rotate(rot_a), .rot_control(rotc_a),
    .scanlines(scan_a), .en_mixing(mix_a), .enable_fm(fm_a), .enable_psg(psg_a),
    .dip_test(test_a), .dip_flip(flip_a), .dip_fxlevel(fx_a), .dip_core(core_a),
    .dip_pause(pause_a), .dip_change(chg_a)
  );

  jtframe_dip_ctrl #(
    .SW(64), .DIPLSB(16), .DIPW(16), .DIP_DEF(DIP_DEF), .SETTLE(SETTLE),
    .PAUSE_TO(64), .VERTICAL(1), .MISTER(1)
  ) dut_v (
    .clk(clk), .rst_n(rst_n), .status(status), .game_pause(gp_v), .vb(vb_v),
    .hdmi_arx(arx_v), .hdmi_ary(ary_v), .rotate(rot_v), .rot_control(rotc_v),
    .scanlines(scan_v), .en_mixing(mix_v), .enable_fm(fm_v), .enable_psg(psg_v),
    .dip_test(test_v), .dip_flip(flip_v), .dip_fxlevel(fx_v), .dip_core(core_v),
    .dip_pause(pause_v), .dip_change(chg_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference decode written from the option rules of the OSD menu.
  function automatic dec_t model(input bit vert, input bit mister, input logic [63:0] s);
    dec_t d;
    bit   tate, rotc, swap;
    tate = vert && (mister ? s[13] : 1'b1);
    rotc = !mister && s[13];
    swap = vert ? tate : 1'b1;
    if (s[2])      begin d.arx = 8'd16; d.ary = 8'd9; end
    else if (swap) begin d.arx = 8'd4;  d.ary = 8'd3; end
    else           begin d.arx = 8'd3;  d.ary = 8'd4; end
    d.rotate = {s[12], tate && !rotc};
    d.rotc   = rotc;
    d.scan   = s[5:3];
    d.mix    = !s[9];
    d.fm     = !s[8];
    d.psg    = !s[7];
    d.test   = !s[6];
    d.flip   = s[12];
    d.fx     = 2'd2 ^ s[11:10];
    d.core   = s[31:16];
    return d;
  endfunction

  function automatic dec_t sample_a();
    return {arx_a, ary_a, rot_a, rotc_a, scan_a, mix_a, fm_a, psg_a, test_a, flip_a, fx_a, core_a};
  endfunction

  function automatic dec_t sample_v();
    return {arx_v, ary_v, rot_v, rotc_v, scan_v, mix_v, fm_v, psg_v, test_v, flip_v, fx_v, core_v};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a status value for 'hold' cycles; a value commits once it has been
  // presented for SETTLE consecutive cycles and differs from the last commit.
  task automatic apply(input logic [63:0] w, input int hold);
    if (w !== cur_word) run = 0;
    cur_word = w;
    status   = w;
    if (run < SETTLE && run + hold >= SETTLE && w != committed) begin
      exp_a.push_back(model(1'b0, 1'b1, w));
      exp_v.push_back(model(1'b1, 1'b1, w));
      committed = w;
    end
    run += hold;
    tick(hold);
  endtask

  // Decode monitors: consume one expectation per change strobe.
  always @(negedge clk) begin
    if (rst_n && chg_a) begin
      if (exp_a.size() == 0) check("change_a_expected", 64'(exp_a.size() != 0), 64'd1);
      else check("decode_a", 64'(sample_a()), 64'(exp_a.pop_front()));
    end
    if (rst_n && chg_v) begin
      if (exp_v.size() == 0) check("change_v_expected", 64'(exp_v.size() != 0), 64'd1);
      else check("decode_v", 64'(sample_v()), 64'(exp_v.pop_front()));
    end
  end

  // Pause monitors: every dip_pause transition must match a queued edge.
  always @(negedge clk) begin
    if (pause_a !== prev_pause_a) begin
      prev_pause_a <= pause_a;
      if (pex_a.size() == 0) check("pause_a_expected", 64'(pex_a.size() != 0), 64'd1);
      else check("pause_a_edge", 64'({pause_a, cyc}), 64'(pex_a.pop_front()));
    end
    if (pause_v !== prev_pause_v) begin
      prev_pause_v <= pause_v;
      if (pex_v.size() == 0) check("pause_v_expected", 64'(pex_v.size() != 0), 64'd1);
      else check("pause_v_edge", 64'({pause_v, cyc}), 64'(pex_v.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w0, w1, w;
    int          hold;

    rst_n = 1'b0; status = INIT; gp_a = 1'b0; vb_a = 1'b0; gp_v = 1'b0; vb_v = 1'b0;
    cur_word = INIT; committed = INIT; run = 0;
    tick(3);
    check("reset_decode_a", 64'(sample_a()), 64'(model(1'b0, 1'b1, INIT)));
    check("reset_decode_v", 64'(sample_v()), 64'(model(1'b1, 1'b1, INIT)));
    check("reset_pause_a", 64'(pause_a), 64'd1);
    check("reset_change_a", 64'(chg_a), 64'd0);
    check("reset_arx_a", 64'(arx_a), 64'd4);
    check("reset_ary_v", 64'(ary_v), 64'd4);
    rst_n = 1'b1;

    // Widescreen commit after exactly SETTLE cycles.
    w0 = INIT | 64'h4;
    apply(w0, SETTLE);
    apply(w0, 4);
    check("wide_arx_a", 64'(arx_a), 64'd16);
    check("wide_ary_a", 64'(ary_a), 64'd9);

    // Short glitch on the FM enable bit must not commit.
    apply(w0 ^ 64'h100, 10);
    apply(w0, 20);
    check("glitch_fm_a", 64'(fm_a), 64'd1);

    // One cycle short of settling, then exactly settled.
    w1 = w0 | 64'h2000;
    apply(w1, SETTLE - 1);
    apply(w0, 5);
    apply(w1, SETTLE);

    // Random status traffic around the settle boundary.
    for (int i = 0; i < 30; i++) begin
      do begin
        w    = {$urandom, $urandom};
        w[1] = 1'b0;
      end while (w == cur_word);
      case ($urandom_range(0, 4))
        0:       hold = SETTLE - 1;
        1:       hold = SETTLE;
        2:       hold = SETTLE + 1;
        3:       hold = $urandom_range(1, 8);
        default: hold = $urandom_range(18, 40);
      endcase
      apply(w, hold);
    end
    apply(cur_word, SETTLE + 4);
    tick(4);

    // Pause on a vblank edge 500 cycles after the request.
    gp_a = 1'b1;
    tick(500);
    vb_a = 1'b1;
    pex_a.push_back({1'b0, cyc + 32'd1});
    tick(3);
    vb_a = 1'b0;
    tick(20);

    // Request returns while waiting to resume: stay paused.
    gp_a = 1'b0;
    tick(3);
    gp_a = 1'b1;
    tick(10);

    // Resume on a vblank edge.
    gp_a = 1'b0;
    tick(30);
    vb_a = 1'b1;
    pex_a.push_back({1'b1, cyc + 32'd1});
    tick(3);
    vb_a = 1'b0;
    tick(5);

    // Cancel arriving with the vblank edge wins.
    gp_a = 1'b1;
    tick(5);
    gp_a = 1'b0;
    vb_a = 1'b1;
    tick(3);
    vb_a = 1'b0;
    tick(10);
    check("cancel_pause_a", 64'(pause_a), 64'd1);

    // Timeouts with vblank held low on the vertical instance.
    gp_v = 1'b1;
    pex_v.push_back({1'b0, cyc + 32'd65});
    tick(80);
    gp_v = 1'b0;
    pex_v.push_back({1'b1, cyc + 32'd65});
    tick(80);

    // Reset while paused.
    gp_a = 1'b1;
    tick(5);
    vb_a = 1'b1;
    pex_a.push_back({1'b0, cyc + 32'd1});
    tick(4);
    pex_a.push_back({1'b1, cyc});
    rst_n = 1'b0;
    status = INIT; cur_word = INIT; committed = INIT; run = 0;
    tick(2);
    check("midreset_pause_a", 64'(pause_a), 64'd1);
    check("midreset_decode_a", 64'(sample_a()), 64'(model(1'b0, 1'b1, INIT)));
    check("midreset_decode_v", 64'(sample_v()), 64'(model(1'b1, 1'b1, INIT)));
    rst_n = 1'b1;

    // vblank already high on release is not an edge.
    tick(10);
    check("no_edge_on_release_a", 64'(pause_a), 64'd1);
    vb_a = 1'b0;
    tick(2);
    vb_a = 1'b1;
    pex_a.push_back({1'b0, cyc + 32'd1});
    tick(2);
    gp_a = 1'b0;
    vb_a = 1'b0;
    tick(2);
    vb_a = 1'b1;
    pex_a.push_back({1'b1, cyc + 32'd1});
    tick(3);
    vb_a = 1'b0;
    tick(SETTLE + 5);

    check("decode_a_queue_drained", 64'(exp_a.size()), 64'd0);
    check("decode_v_queue_drained", 64'(exp_v.size()), 64'd0);
    check("pause_a_queue_drained", 64'(pex_a.size()), 64'd0);
    check("pause_v_queue_drained", 64'(pex_v.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
